float_add_sched: RTL and testbench

Two-requester scheduler for the shared 8-bit float adder datapath. The float format is exp[7:5] and mant[4:0], unsigned, with no hidden bit. Two clients submit operand pairs through valid/ready request ports. The block arbitrates round-robin, drives one internal `float_add` instance from registered operands, captures the sum, and returns it on a single response port tagged with the requester ID.

---
 rtl/float_add_sched.sv | 178 +++++++++++++++++
 tb/tb_float_add_sched.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_add_sched.sv
// Two-requester round-robin scheduler around one shared 8-bit float adder
// (exp[7:5], mant[4:0], no hidden bit); results return tagged with the owner id.

module float_add (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] sum_o
);

  logic [2:0] exp_big_s;
  logic [2:0] exp_small_s;
  logic [2:0] shift_s;
  logic [4:0] mant_big_s;
  logic [4:0] mant_small_s;
  logic [4:0] mant_aligned_s;
  logic [5:0] mant_sum_s;

  // Order by exponent, align the small mantissa, add, renormalise on carry
  always_comb begin
    exp_big_s      = 3'd0;
    exp_small_s    = 3'd0;
    mant_big_s     = 5'd0;
    mant_small_s   = 5'd0;
    sum_o          = 8'h00;
    if (a_i[7:5] >= b_i[7:5]) begin
      exp_big_s    = a_i[7:5];
      mant_big_s   = a_i[4:0];
      exp_small_s  = b_i[7:5];
      mant_small_s = b_i[4:0];
    end else begin
      exp_big_s    = b_i[7:5];
      mant_big_s   = b_i[4:0];
      exp_small_s  = a_i[7:5];
      mant_small_s = a_i[4:0];
    end
    shift_s        = exp_big_s - exp_small_s;
    mant_aligned_s = mant_small_s >> shift_s;
    mant_sum_s     = {1'b0, mant_big_s} + {1'b0, mant_aligned_s};
    if (mant_sum_s[5]) begin
      if (exp_big_s == 3'd7) begin
        sum_o = 8'hFF;
      end else begin
        sum_o = {exp_big_s + 3'd1, 1'b1, mant_sum_s[4:1]};
      end
    end else begin
      sum_o = {exp_big_s, mant_sum_s[4:0]};
    end
  end

endmodule

module float_add_sched #(
  parameter int SAT_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [7:0]           req0_a,
  input  logic [7:0]           req0_b,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [7:0]           req1_a,
  input  logic [7:0]           req1_b,
  output logic                 req1_ready,
  output logic                 resp_valid,
  output logic [7:0]           resp_data,
  output logic                 resp_id,
  input  logic                 resp_ready,
  output logic                 busy,
  output logic [SAT_CNT_W-1:0] sat_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                 state_q;
  logic                   last_grant_q;
  logic                   id_q;
  logic [7:0]             op_a_q;
  logic [7:0]             op_b_q;
  logic                   resp_valid_q;
  logic [7:0]             resp_data_q;
  logic                   resp_id_q;
  logic                   busy_q;
  logic [SAT_CNT_W-1:0]   sat_count_q;

  logic                   grant0_s;
  logic                   grant1_s;
  logic                   accept_s;
  logic [7:0]             sum_s;

  function automatic logic [SAT_CNT_W-1:0] sat_inc(input logic [SAT_CNT_W-1:0] cnt);
    if (&cnt) begin
      return cnt;
    end else begin
      return cnt + SAT_CNT_W'(1);
    end
  endfunction

  // A lone requester always wins; a tie goes to whoever was not served last.
  assign grant0_s   = req0_valid & (~req1_valid | last_grant_q);
  assign grant1_s   = req1_valid & (~req0_valid | ~last_grant_q);
  assign req0_ready = ~rst & (state_q == IDLE) & grant0_s;
  assign req1_ready = ~rst & (state_q == IDLE) & grant1_s;
  assign accept_s   = req0_ready | req1_ready;

  float_add u_float_add (
    .a_i   (op_a_q),
    .b_i   (op_b_q),
    .sum_o (sum_s)
  );

  // Scheduler FSM with registered response, busy and saturation counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      op_a_q       <= 8'h00;
      op_b_q       <= 8'h00;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 8'h00;
      resp_id_q    <= 1'b0;
      busy_q       <= 1'b0;
      sat_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            op_a_q       <= req1_ready ? req1_a : req0_a;
            op_b_q       <= req1_ready ? req1_b : req0_b;
            id_q         <= req1_ready;
            last_grant_q <= req1_ready;
            busy_q       <= 1'b1;
            state_q      <= EXEC;
          end else begin
            state_q      <= IDLE;
          end
        end
        EXEC: begin
          resp_data_q  <= sum_s;
          resp_id_q    <= id_q;
          resp_valid_q <= 1'b1;
          if (sum_s == 8'hFF) begin
            sat_count_q <= sat_inc(sat_count_q);
          end else begin
            sat_count_q <= sat_count_q;
          end
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end else begin
            state_q      <= RESP;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign busy       = busy_q;
  assign sat_count  = sat_count_q;

endmodule

// File: tb/tb_float_add_sched.sv
// Self-checking bench for float_add_sched: directed vector table, random ops
// against a plain-arithmetic reference, and round-robin/stall/reset sequences.

module tb_float_add_sched;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       resp_id;
  logic       resp_ready;
  logic       busy;
  logic [7:0] sat_count;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_sat  = 0;
  logic lg       = 1'b1;

  typedef struct {
    logic       id;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[9];

  float_add_sched #(.SAT_CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_ready (resp_ready),
    .busy       (busy),
    .sat_count  (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: value of exp/mant rules in integer arithmetic
  function automatic logic [7:0] ref_add(input logic [7:0] a, input logic [7:0] b);
    int ai, bi, ea, eb, ma, mb, eh, s;
    ai = a; bi = b;
    ea = ai / 32; ma = ai % 32;
    eb = bi / 32; mb = bi % 32;
    if (ea >= eb) begin
      eh = ea; s = ma + (mb >> (ea - eb));
    end else begin
      eh = eb; s = mb + (ma >> (eb - ea));
    end
    if (s < 32) return 8'(eh * 32 + s);
    else if (eh == 7) return 8'hFF;
    else return 8'((eh + 1) * 32 + s / 2);
  endfunction

  // Single isolated op with exact cycle timing; called at a negedge while idle
  task automatic do_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] e, input string tag);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end
    #1;
    chk({tag, ".ready"}, {30'd0, req1_ready, req0_ready}, id ? 32'd2 : 32'd1);
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk({tag, ".busy_exec"}, busy, 32'd1);
    chk({tag, ".no_early_valid"}, resp_valid, 32'd0);
    @(posedge clk); @(negedge clk);
    chk({tag, ".resp_valid"}, resp_valid, 32'd1);
    chk({tag, ".resp_data"}, resp_data, e);
    chk({tag, ".resp_id"}, resp_id, id);
    if (e == 8'hFF) exp_sat++;
    lg = id;
    @(posedge clk); @(negedge clk);
    chk({tag, ".done_valid"}, resp_valid, 32'd0);
    chk({tag, ".done_busy"}, busy, 32'd0);
  endtask

  task automatic wait_resp(input string tag);
    int w;
    w = 0;
    while (resp_valid !== 1'b1 && w < 20) begin
      @(posedge clk); @(negedge clk);
      w++;
    end
    chk({tag, ".resp_timeout"}, (w < 20), 32'd1);
  endtask

  task automatic wait_ready(input string tag);
    int w;
    w = 0;
    #1;
    while (!(req0_ready || req1_ready) && w < 20) begin
      @(posedge clk); @(negedge clk); #1;
      w++;
    end
    chk({tag, ".ready_timeout"}, (w < 20), 32'd1);
  endtask

  initial begin
    logic [7:0] opa[2];
    logic [7:0] opb[2];
    logic [7:0] e;
    logic       g;
    logic       rid;

    tbl[0] = '{1'b0, 8'h21, 8'h21, 8'h22};
    tbl[1] = '{1'b1, 8'h3F, 8'h3F, 8'h5F};
    tbl[2] = '{1'b0, 8'h3F, 8'h3F, 8'h5F};
    tbl[3] = '{1'b1, 8'hFF, 8'h01, 8'hFF};
    tbl[4] = '{1'b0, 8'hFF, 8'hE1, 8'hFF};
    tbl[5] = '{1'b1, 8'hE1, 8'hE1, 8'hE2};
    tbl[6] = '{1'b0, 8'h00, 8'h00, 8'h00};
    tbl[7] = '{1'b1, 8'hE0, 8'h1F, 8'hE0};
    tbl[8] = '{1'b0, 8'h1F, 8'h20, 8'h2F};

    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 8'h00; req0_b = 8'h00; req1_a = 8'h00; req1_b = 8'h00;
    resp_ready = 1'b1;
    #2;
    chk("rst.resp_valid", resp_valid, 32'd0);
    chk("rst.resp_data", resp_data, 32'd0);
    chk("rst.resp_id", resp_id, 32'd0);
    chk("rst.busy", busy, 32'd0);
    chk("rst.sat_count", sat_count, 32'd0);
    chk("rst.readys", {req1_ready, req0_ready}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      do_op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("vec%0d", i));
    end
    chk("vec.sat_count", sat_count, 32'd2);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rid = 1'($urandom_range(0, 1));
      do_op(rid, ra, rb, ref_add(ra, rb), $sformatf("rnd%0d", i));
    end
    chk("rnd.sat_count", sat_count, (exp_sat > 255) ? 32'd255 : 32'(exp_sat));

    rst = 1'b1;
    #1;
    chk("rst2.sat_count", sat_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    lg = 1'b1;
    exp_sat = 0;

    // Round-robin with both requesters continuously valid
    for (int i = 0; i < 2; i++) begin
      opa[i] = 8'($urandom_range(0, 255));
      opb[i] = 8'($urandom_range(0, 255));
    end
    req0_a = opa[0]; req0_b = opb[0]; req1_a = opa[1]; req1_b = opb[1];
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_ready($sformatf("rr%0d", k));
      g = ~lg;
      chk($sformatf("rr%0d.grant", k), {req1_ready, req0_ready}, g ? 32'd2 : 32'd1);
      e = ref_add(opa[g], opb[g]);
      lg = g;
      @(posedge clk); @(negedge clk);
      opa[g] = 8'($urandom_range(0, 255));
      opb[g] = 8'($urandom_range(0, 255));
      if (g) begin req1_a = opa[1]; req1_b = opb[1]; end
      else begin req0_a = opa[0]; req0_b = opb[0]; end
      wait_resp($sformatf("rr%0d", k));
      chk($sformatf("rr%0d.data", k), resp_data, e);
      chk($sformatf("rr%0d.id", k), resp_id, g);
      @(posedge clk); @(negedge clk);
    end

    // Back-pressure: stall the response for 10 cycles
    resp_ready = 1'b0;
    wait_ready("bp");
    g = ~lg;
    chk("bp.grant", {req1_ready, req0_ready}, g ? 32'd2 : 32'd1);
    e = ref_add(opa[g], opb[g]);
    lg = g;
    @(posedge clk); @(negedge clk);
    opa[g] = 8'($urandom_range(0, 255));
    opb[g] = 8'($urandom_range(0, 255));
    if (g) begin req1_a = opa[1]; req1_b = opb[1]; end
    else begin req0_a = opa[0]; req0_b = opb[0]; end
    wait_resp("bp");
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("bp%0d.valid", c), resp_valid, 32'd1);
      chk($sformatf("bp%0d.data", c), resp_data, e);
      chk($sformatf("bp%0d.id", c), resp_id, g);
      chk($sformatf("bp%0d.readys", c), {req1_ready, req0_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    wait_ready("bp_next");
    g = ~lg;
    chk("bp_next.grant", {req1_ready, req0_ready}, g ? 32'd2 : 32'd1);
    e = ref_add(opa[g], opb[g]);
    lg = g;
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_resp("bp_next");
    chk("bp_next.data", resp_data, e);
    chk("bp_next.id", resp_id, g);
    @(posedge clk); @(negedge clk);

    // Async reset while in EXEC
    req0_valid = 1'b1; req0_a = 8'h21; req0_b = 8'h21;
    #1;
    chk("rx.ready", req0_ready, 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rx.resp_valid", resp_valid, 32'd0);
    chk("rx.resp_data", resp_data, 32'd0);
    chk("rx.busy", busy, 32'd0);
    chk("rx.readys", {req1_ready, req0_ready}, 32'd0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    lg = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("rx%0d.no_stale", c), {busy, resp_valid}, 32'd0);
    end

    // Async reset while stalled in RESP, then check the post-reset tie
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'hE1;
    #1;
    chk("rr_rst.ready", req0_ready, 32'd1);
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    wait_resp("rr_rst");
    chk("rr_rst.data", resp_data, 32'hFF);
    chk("rr_rst.sat", sat_count, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rr_rst.resp_valid", resp_valid, 32'd0);
    chk("rr_rst.resp_data", resp_data, 32'd0);
    chk("rr_rst.resp_id", resp_id, 32'd0);
    chk("rr_rst.busy", busy, 32'd0);
    chk("rr_rst.sat_count", sat_count, 32'd0);
    req0_valid = 1'b1; req0_a = 8'h41; req0_b = 8'h22;
    req1_valid = 1'b1; req1_a = 8'h3F; req1_b = 8'h3F;
    #1;
    chk("rr_rst.readys_in_rst", {req1_ready, req0_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    resp_ready = 1'b1;
    #1;
    chk("rr_rst.no_stale", resp_valid, 32'd0);
    chk("rr_rst.tie", {req1_ready, req0_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    wait_resp("post0");
    chk("post0.data", resp_data, ref_add(8'h41, 8'h22));
    chk("post0.id", resp_id, 32'd0);
    @(posedge clk); @(negedge clk);
    #1;
    chk("post1.ready", {req1_ready, req0_ready}, 32'd2);
    @(posedge clk); @(negedge clk);
    req1_valid = 1'b0;
    wait_resp("post1");
    chk("post1.data", resp_data, 32'h5F);
    chk("post1.id", resp_id, 32'd1);
    @(posedge clk); @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
